// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared response record and LFSR constants for the RAM port arbiter
package ram_arb_pkg;
  localparam int ID_W = 3;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  typedef struct packed {
    logic valid;
    logic [ID_W-1:0] id;
    logic we;
  } resp_t;
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/ram_arb_rr.sv
// ram_arb_rr: round-robin pointer with rotate-priority one-hot select
module ram_arb_rr #(
  parameter int NUM_REQ = 2,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic [NUM_REQ-1:0] req,
  input  logic stall,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0] idx,
  output logic valid
);
  localparam logic [IW:0] LAST = (IW+1)'(NUM_REQ - 1);
  logic [IW-1:0] ptr;
  logic [IW:0] j;
  always_comb begin
    gnt = '0;
    idx = '0;
    valid = 1'b0;
    j = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = {1'b0, ptr} + (IW+1)'(i);
      j = j > LAST ? j - (IW+1)'(NUM_REQ) : j;
      if (!valid && !stall && req[j[IW-1:0]]) begin
        valid = 1'b1;
        gnt[j[IW-1:0]] = 1'b1;
        idx = j[IW-1:0];
      end
    end
  end
  always_ff @(posedge clk_i)
    if (!rst_ni) ptr <= '0;
    else if (valid) ptr <= ({1'b0, idx} == LAST) ? '0 : idx + 1'b1;
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin sharing of one RAM port between NUM_REQ OBI-style requesters
// Define RAM_ARB_STALL_EN to insert LFSR-driven random grant stalls.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_WIDTH = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_REQ-1:0] we_i,
  input  logic [NUM_REQ*4-1:0] be_i,
  input  logic [NUM_REQ*32-1:0] wdata_i,
  output logic [NUM_REQ-1:0] rvalid_o,
  output logic [31:0] rdata_o,
  output logic ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  output logic ram_we_o,
  output logic [3:0] ram_be_o,
  input  logic [31:0] ram_rdata_i
);
  localparam int IW = $clog2(NUM_REQ);
  logic stall, valid;
  logic [IW-1:0] idx;
  resp_t resp;
  logic [ADDR_WIDTH-1:0] addr_a [NUM_REQ];
  logic [3:0] be_a [NUM_REQ];
  logic [31:0] wdata_a [NUM_REQ];
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign addr_a[i] = addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign be_a[i] = be_i[i*4 +: 4];
    assign wdata_a[i] = wdata_i[i*32 +: 32];
    assign rvalid_o[i] = rst_ni && resp.valid && resp.id == ID_W'(i);
  end
`ifdef RAM_ARB_STALL_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk_i) lfsr <= !rst_ni ? LFSR_SEED : lfsr_next(lfsr);
  assign stall = !rst_ni || lfsr[0];
`else
  assign stall = !rst_ni;
`endif
  ram_arb_rr #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .req(req_i),
    .stall(stall),
    .gnt(gnt_o),
    .idx(idx),
    .valid(valid)
  );
  assign ram_en_o = valid;
  assign ram_addr_o = valid ? addr_a[idx] : '0;
  assign ram_wdata_o = valid ? wdata_a[idx] : '0;
  assign ram_be_o = valid ? be_a[idx] : '0;
  assign ram_we_o = valid && we_i[idx];
  // response is discarded by reset even if it was already registered
  always_ff @(posedge clk_i)
    if (!rst_ni) resp <= '0;
    else begin
      resp.valid <= valid;
      resp.id <= ID_W'(idx);
      resp.we <= we_i[idx];
    end
  assign rdata_o = (rst_ni && resp.valid && !resp.we) ? ram_rdata_i : '0;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed plus random checks against a behavioural arbiter/RAM model
module tb_ram_port_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  logic [1:0] req2, we2, gnt2, rvalid2;
  logic [15:0] addr2;
  logic [7:0] be2, ram_addr2;
  logic [63:0] wdata2;
  logic [31:0] rdata2, ram_wdata2, ram_rdata2;
  logic ram_en2, ram_we2;
  logic [3:0] ram_be2;
  logic [2:0] req3, we3, gnt3, rvalid3;
  logic [23:0] addr3;
  logic [11:0] be3;
  logic [95:0] wdata3;
  logic [31:0] rdata3, ram_wdata3, ram_rdata3;
  logic ram_en3, ram_we3;
  logic [7:0] ram_addr3;
  logic [3:0] ram_be3;

  ram_port_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req2), .gnt_o(gnt2), .addr_i(addr2), .we_i(we2),
    .be_i(be2), .wdata_i(wdata2), .rvalid_o(rvalid2), .rdata_o(rdata2), .ram_en_o(ram_en2),
    .ram_addr_o(ram_addr2), .ram_wdata_o(ram_wdata2), .ram_we_o(ram_we2), .ram_be_o(ram_be2),
    .ram_rdata_i(ram_rdata2)
  );
  ram_port_arbiter #(.NUM_REQ(3), .ADDR_WIDTH(8)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req3), .gnt_o(gnt3), .addr_i(addr3), .we_i(we3),
    .be_i(be3), .wdata_i(wdata3), .rvalid_o(rvalid3), .rdata_o(rdata3), .ram_en_o(ram_en3),
    .ram_addr_o(ram_addr3), .ram_wdata_o(ram_wdata3), .ram_we_o(ram_we3), .ram_be_o(ram_be3),
    .ram_rdata_i(ram_rdata3)
  );

  // RAM behind the 2-requester arbiter: word-aligned, byte enables, 1-cycle read latency
  logic [31:0] mem [64];
  always @(posedge clk)
    if (ram_en2 && ram_we2) begin
      for (int b = 0; b < 4; b++)
        if (ram_be2[b]) mem[ram_addr2[7:2]][b*8 +: 8] <= ram_wdata2[b*8 +: 8];
    end else if (ram_en2) ram_rdata2 <= mem[ram_addr2[7:2]];

  int checks, errors;
  int ptr2, ptr3, last_k2, pend_id;
  logic pend_v, pend_we, last_en2;
  logic [31:0] pend_data;
  logic [15:0] lfsr;
  logic [1:0] last_gnt2;
  logic [2:0] last_gnt3;
  logic [31:0] ref_mem [64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [7:0] r, input int p, input int n);
    for (int i = 0; i < n; i++) if (r[(p + i) % n]) return (p + i) % n;
    return -1;
  endfunction

  task automatic step();
    int k2, k3;
    logic st, ew;
    logic [1:0] eg2, erv;
    logic [2:0] eg3;
    logic [7:0] ea;
    logic [3:0] eb;
    logic [31:0] ed;
    @(negedge clk);
    st = !rst_n;
`ifdef RAM_ARB_STALL_EN
    st = st || lfsr[0];
`endif
    k2 = st ? -1 : pick({6'b0, req2}, ptr2, 2);
    k3 = st ? -1 : pick({5'b0, req3}, ptr3, 3);
    eg2 = '0; eg3 = '0; erv = '0; ea = '0; eb = '0; ed = '0; ew = 1'b0;
    if (k2 >= 0) begin
      eg2[k2] = 1'b1;
      ea = addr2[k2*8 +: 8];
      eb = be2[k2*4 +: 4];
      ed = wdata2[k2*32 +: 32];
      ew = we2[k2];
    end
    if (k3 >= 0) eg3[k3] = 1'b1;
    if (pend_v && rst_n) erv[pend_id] = 1'b1;
    chk("gnt2", 32'(gnt2), 32'(eg2));
    chk("ram_en2", 32'(ram_en2), 32'(k2 >= 0));
    chk("ram_addr2", 32'(ram_addr2), 32'(ea));
    chk("ram_we2", 32'(ram_we2), 32'(ew));
    chk("ram_be2", 32'(ram_be2), 32'(eb));
    chk("ram_wdata2", ram_wdata2, ed);
    chk("rvalid2", 32'(rvalid2), 32'(erv));
    chk("rdata2", rdata2, (pend_v && rst_n && !pend_we) ? pend_data : 32'h0);
    chk("gnt3", 32'(gnt3), 32'(eg3));
    chk("ram_en3", 32'(ram_en3), 32'(k3 >= 0));
    last_gnt2 = gnt2;
    last_gnt3 = gnt3;
    last_en2 = ram_en2;
    last_k2 = k2;
    if (!rst_n) begin
      ptr2 = 0; ptr3 = 0; pend_v = 1'b0; lfsr = 16'hACE1;
    end else begin
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      pend_v = k2 >= 0;
      if (k2 >= 0) begin
        ptr2 = (k2 + 1) % 2;
        pend_id = k2;
        pend_we = ew;
        pend_data = ref_mem[ea[7:2]];
        if (ew) for (int b = 0; b < 4; b++) if (eb[b]) ref_mem[ea[7:2]][b*8 +: 8] = ed[b*8 +: 8];
      end
      if (k3 >= 0) ptr3 = (k3 + 1) % 3;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_access(input int k, input logic [7:0] a, input logic w, input logic [3:0] b,
                           input logic [31:0] d);
    bit got = 1'b0;
    addr2[k*8 +: 8] = a; we2[k] = w; be2[k*4 +: 4] = b; wdata2[k*32 +: 32] = d; req2[k] = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      got = last_k2 == k;
    end
    req2[k] = 1'b0;
    chk("grant_wait", 32'(got), 32'd1);
  endtask

  initial begin
    checks = 0; errors = 0; ptr2 = 0; ptr3 = 0; pend_v = 1'b0; pend_we = 1'b0; pend_id = 0;
    pend_data = '0; lfsr = 16'hACE1; last_k2 = -1;
    for (int i = 0; i < 64; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    rst_n = 1'b0;
    req2 = '0; we2 = '0; addr2 = '0; be2 = '0; wdata2 = '0;
    req3 = '0; we3 = '0; addr3 = '0; be3 = '0; wdata3 = '0; ram_rdata3 = '0;
    repeat (2) step();
    chk("rst_gnt2", 32'(gnt2), 32'd0);
    chk("rst_rvalid2", 32'(rvalid2), 32'd0);
    chk("rst_rdata2", rdata2, 32'd0);
    chk("rst_en2", 32'(ram_en2), 32'd0);
    rst_n = 1'b1;
    do_access(0, 8'h10, 1'b1, 4'hF, 32'hDEADBEEF);
    do_access(0, 8'h20, 1'b1, 4'hF, 32'h11223344);
    do_access(0, 8'h10, 1'b0, 4'h0, 32'h0);
    chk("read_rvalid", 32'(rvalid2), 32'h1);
    chk("read_data", rdata2, 32'hDEADBEEF);
    do_access(1, 8'h20, 1'b1, 4'b0100, 32'h00AB0000);
    chk("bytewr_rvalid", 32'(rvalid2), 32'h2);
    chk("bytewr_rdata", rdata2, 32'h0);
    do_access(0, 8'h20, 1'b0, 4'h0, 32'h0);
    chk("bytewr_readback", rdata2, 32'h11AB3344);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    addr2 = {8'h10, 8'h20}; we2 = 2'b00; req2 = 2'b11; req3 = 3'b101;
    for (int i = 0; i < 6; i++) begin
      step();
`ifndef RAM_ARB_STALL_EN
      chk("cont_gnt", 32'(last_gnt2), (i % 2) ? 32'h2 : 32'h1);
      chk("cont_rvalid", 32'(rvalid2), (i % 2) ? 32'h2 : 32'h1);
      if (i < 4) chk("wrap3_gnt", 32'(last_gnt3), (i % 2) ? 32'h4 : 32'h1);
`endif
    end
    req3 = '0;
    req2 = 2'b01;
    do_access(0, 8'h10, 1'b0, 4'h0, 32'h0);
    req2 = 2'b01;
    rst_n = 1'b0;
    step();
    chk("rstmid_gnt", 32'(last_gnt2), 32'd0);
    chk("rstmid_en", 32'(last_en2), 32'd0);
    rst_n = 1'b1;
    req2 = '0;
    chk("rstmid_rvalid", 32'(rvalid2), 32'd0);
    step();
    req2 = 2'b11;
    step();
`ifndef RAM_ARB_STALL_EN
    chk("rstmid_ptr", 32'(last_gnt2), 32'h1);
`endif
    req2 = '0;
    step();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (req2[k]) begin
          if (last_k2 == k) begin
            if ($urandom_range(1) == 1) begin
              addr2[k*8 +: 8] = 8'($urandom); we2[k] = 1'($urandom);
              be2[k*4 +: 4] = 4'($urandom); wdata2[k*32 +: 32] = $urandom;
            end else req2[k] = 1'b0;
          end else if ($urandom_range(7) == 0) req2[k] = 1'b0;
        end else if ($urandom_range(2) == 0) begin
          req2[k] = 1'b1;
          addr2[k*8 +: 8] = 8'($urandom); we2[k] = 1'($urandom);
          be2[k*4 +: 4] = 4'($urandom); wdata2[k*32 +: 32] = $urandom;
        end
      end
      req3 = 3'($urandom);
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single data port (port B) of the example-testbench dual-port RAM between NUM_REQ OBI-style requesters, e.g. core data interface and testbench loader/debug master.
- Round-robin arbitration, one granted access per cycle.
- Drives the RAM's en/addr/wdata/we/be and routes the 1-cycle-latency read data back as rvalid/rdata to the owning requester.
- Sits between the requesters and the RAM in the testbench top.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_WIDTH, 8, byte-address width, equal to the RAM's ADDR_WIDTH.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_ni  in  1  reset; synchronous, active-low.
- req_i  in  NUM_REQ  per-requester access request.
- gnt_o  out  NUM_REQ  one-hot grant, combinational from req_i and state.
- addr_i  in  NUM_REQ x ADDR_WIDTH  byte address per requester.
- we_i  in  NUM_REQ  write enable per requester.
- be_i  in  NUM_REQ x 4  byte enables per requester.
- wdata_i  in  NUM_REQ x 32  write data per requester.
- rvalid_o  out  NUM_REQ  one-hot response valid.
- rdata_o  out  32  response data, shared by all requesters.
- ram_en_o  out  1  RAM port enable.
- ram_addr_o  out  ADDR_WIDTH  RAM address.
- ram_wdata_o  out  32  RAM write data.
- ram_we_o  out  1  RAM write enable.
- ram_be_o  out  4  RAM byte enables.
- ram_rdata_i  in  32  RAM read data, valid 1 cycle after a read enable.

Behaviour:
- Reset (rst_ni low at a clock edge):
  - rr_ptr = 0; resp_valid = 0; resp_id = 0; resp_we = 0; LFSR = seed.
  - During and after reset: rvalid_o = 0, rdata_o = 0, ram_en_o = 0.
- Arbitration:
  - Search starts at index rr_ptr, ascending, wrapping modulo NUM_REQ; the first asserted req_i wins.
  - gnt_o is one-hot or zero, and is zero whenever rst_ni = 0.
- Handshake:
  - Handshake completes in a cycle with req_i[k] = 1 and gnt_o[k] = 1.
  - A requester holds req_i and its address/data stable until granted.
  - Dropping req_i before grant is legal; nothing is issued.
- Issue in grant cycle (combinational):
  - ram_en_o = 1; ram_addr_o/we/be/wdata = winner's inputs.
  - With no grant: ram_en_o = 0 and other RAM outputs = 0.
- Pointer update: on a grant to k, rr_ptr <= (k + 1) mod NUM_REQ; otherwise it holds.
- Response (fixed latency of 1 cycle after grant):
  - In the grant cycle: resp_valid <= 1, resp_id <= k, resp_we <= we_i[k].
  - Next cycle: rvalid_o[resp_id] = 1.
  - rdata_o = ram_rdata_i for a read, 32'h0 for a write.
  - Writes also get an rvalid.
- Throughput: back-to-back grants in consecutive cycles are allowed; a new grant may coincide with the previous response.
- Fairness: with all requesters asserting continuously, each is granted exactly once per NUM_REQ cycles.
- Boundary cases:
  - rr_ptr wraps NUM_REQ-1 -> 0.
  - A requester granted in cycle n and re-requesting in n+1 loses to any other waiting requester.
  - Reset asserted in a grant cycle: no gnt_o, the issued access is squashed (ram_en_o = 0), and any pending response is discarded (no rvalid).
- Address alignment: the RAM word-aligns internally; the arbiter forwards the address unmodified.

Optional Feature:
- Macro: RAM_ARB_STALL_EN.
- Defined:
  - 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded 16'hACE1 on reset, advances every cycle.
  - When LFSR[0] = 1, all gnt_o = 0 and ram_en_o = 0 that cycle; requests wait.
  - Purpose: exercise requester grant-wait logic.
- Undefined: no LFSR; a grant is given whenever any req_i = 1.

Decomposition:
- Package ram_arb_pkg holds:
  - resp_t struct {valid, id[$clog2(NUM_REQ)-1:0], we}.
  - LFSR_SEED = 16'hACE1 and the LFSR tap mask constant.
- One sub-module, ram_arb_rr: round-robin pointer register plus rotate-priority one-hot select. It outputs gnt one-hot and winner index, takes a stall input, and updates the pointer on grant.

Test Plan:
- Single read: after writing mem[0x10..0x13], req_i = 01, addr 0x10, we = 0 -> gnt_o = 01 same cycle, rvalid_o = 01 next cycle, rdata_o = 32'hDEADBEEF.
- Byte write: req_i[1] = 1, we = 1, be = 4'b0100, wdata = 32'h00AB0000, addr 0x20, then read 0x20 -> only byte 2 changed to 0xAB; the write's rvalid carries rdata_o = 0.
- Contention: both req_i held for 6 cycles from reset -> grants 01,10,01,10,01,10, and rvalid_o follows each grant by one cycle.
- Pointer wrap and skip: NUM_REQ = 3, req_i = 101 continuous -> grants 001,100,001,100.
- Reset mid-operation: rst_ni low in the grant cycle of a read -> gnt_o = 0, ram_en_o = 0, no rvalid the next cycle, rr_ptr = 0 afterwards.
- RAM_ARB_STALL_EN build: req_i[0] held for 32 cycles -> no grant in cycles where LFSR[0] = 1 (cycle pattern predicted by a bench LFSR model), every granted access still answered after exactly 1 cycle.
